kara_prod_accum: RTL

- Downstream consumer of the combinational Karatsuba multiplier's 2*DATA_W-bit unsigned product.
- Accumulates a stream of products into one dot-product term, one product per accepted beat, closed by a last flag or by a term limit.
- Rounds the fixed-point sum half-up, saturates it to OUT_W bits and presents it on a valid/ready output.
- Sits between the multiplier array and the QFT amplitude writeback.

---
 rtl/kara_prod_accum_if.sv | 28 ++
 rtl/kara_prod_accum.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/kara_prod_accum_if.sv
// Product-in / result-out handshake bundle between the multiplier array,
// the product accumulator and the amplitude writeback.
interface kara_prod_accum_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned OUT_W  = 32,
  parameter int unsigned CNT_W  = 5
);
  logic [2*DATA_W-1:0] prod_i;
  logic                prod_valid;
  logic                prod_last;
  logic                prod_ready;
  logic [OUT_W-1:0]    out_data;
  logic                out_sat;
  logic                out_term_ovf;
  logic [CNT_W-1:0]    out_count;
  logic                out_valid;
  logic                out_ready;

  modport master (
    output prod_i, prod_valid, prod_last, out_ready,
    input  prod_ready, out_data, out_sat, out_term_ovf, out_count, out_valid
  );

  modport slave (
    input  prod_i, prod_valid, prod_last, out_ready,
    output prod_ready, out_data, out_sat, out_term_ovf, out_count, out_valid
  );
endinterface

// File: rtl/kara_prod_accum.sv
// Accumulates a stream of unsigned multiplier products into one dot-product
// term, rounds half-up, saturates to OUT_W bits and offers it on valid/ready.
module kara_prod_accum #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned GUARD_W   = 4,
  parameter int unsigned FRAC_W    = 30,
  parameter int unsigned OUT_W     = 32,
  parameter int unsigned MAX_TERMS = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  kara_prod_accum_if.slave  bus
);
  localparam int unsigned PROD_W = 2 * DATA_W;
  localparam int unsigned ACC_W  = PROD_W + GUARD_W;
  localparam int unsigned R_W    = ACC_W + 1;
  localparam int unsigned CNT_W  = $clog2(MAX_TERMS + 1);

  // The guard bits are what keep the accumulator from wrapping.
  if ((MAX_TERMS == 0) || (MAX_TERMS > (2 ** GUARD_W))) begin : g_bad_terms
    $error("kara_prod_accum: MAX_TERMS must be in 1..2**GUARD_W");
  end
  if (FRAC_W >= ACC_W) begin : g_bad_frac
    $error("kara_prod_accum: FRAC_W must be below ACC_W");
  end

  typedef enum logic [1:0] {IDLE, ACC, ROUND, OUT} state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             term_ovf_q, term_ovf_d;
  logic [OUT_W-1:0] out_data_q, out_data_d;
  logic             out_sat_q, out_sat_d;
  logic             out_term_ovf_q, out_term_ovf_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;
  logic             out_valid_q, out_valid_d;

  logic [R_W-1:0]   rnd_c;
  logic [OUT_W-1:0] sat_data_c;
  logic             sat_c;
  logic             accept_c;

  // Half-up rounding in ACC_W+1 bits so the rounding carry is never lost.
  if (FRAC_W == 0) begin : g_no_round
    assign rnd_c = R_W'(acc_q);
  end else begin : g_round
    localparam logic [R_W-1:0] HALF = R_W'(1) << (FRAC_W - 1);
    assign rnd_c = (R_W'(acc_q) + HALF) >> FRAC_W;
  end

  if (OUT_W < R_W) begin : g_sat
    assign sat_c      = |rnd_c[R_W-1:OUT_W];
    assign sat_data_c = sat_c ? {OUT_W{1'b1}} : rnd_c[OUT_W-1:0];
  end else begin : g_no_sat
    assign sat_c      = 1'b0;
    assign sat_data_c = OUT_W'(rnd_c);
  end

  assign bus.prod_ready   = (state_q == IDLE) || (state_q == ACC);
  assign accept_c         = bus.prod_valid && bus.prod_ready;

  assign bus.out_data     = out_data_q;
  assign bus.out_sat      = out_sat_q;
  assign bus.out_term_ovf = out_term_ovf_q;
  assign bus.out_count    = out_count_q;
  assign bus.out_valid    = out_valid_q;

  // Next-state and datapath decode.
  always_comb begin
    state_d        = state_q;
    acc_d          = acc_q;
    count_d        = count_q;
    term_ovf_d     = term_ovf_q;
    out_data_d     = out_data_q;
    out_sat_d      = out_sat_q;
    out_term_ovf_d = out_term_ovf_q;
    out_count_d    = out_count_q;
    out_valid_d    = out_valid_q;

    case (state_q)
      IDLE: begin
        if (accept_c) begin
          acc_d   = ACC_W'(bus.prod_i);
          count_d = CNT_W'(1);
          if (bus.prod_last || (MAX_TERMS == 1)) begin
            state_d    = ROUND;
            term_ovf_d = !bus.prod_last;
          end else begin
            state_d    = ACC;
            term_ovf_d = 1'b0;
          end
        end
      end
      ACC: begin
        if (accept_c) begin
          acc_d   = acc_q + ACC_W'(bus.prod_i);
          count_d = count_q + CNT_W'(1);
          if (bus.prod_last) begin
            state_d    = ROUND;
            term_ovf_d = 1'b0;
          end else if (count_d == CNT_W'(MAX_TERMS)) begin
            state_d    = ROUND;
            term_ovf_d = 1'b1;
          end
        end
      end
      ROUND: begin
        out_data_d     = sat_data_c;
        out_sat_d      = sat_c;
        out_count_d    = count_q;
        out_term_ovf_d = term_ovf_q;
        out_valid_d    = 1'b1;
        state_d        = OUT;
      end
      OUT: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      acc_q          <= '0;
      count_q        <= '0;
      term_ovf_q     <= 1'b0;
      out_data_q     <= '0;
      out_sat_q      <= 1'b0;
      out_term_ovf_q <= 1'b0;
      out_count_q    <= '0;
      out_valid_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      acc_q          <= acc_d;
      count_q        <= count_d;
      term_ovf_q     <= term_ovf_d;
      out_data_q     <= out_data_d;
      out_sat_q      <= out_sat_d;
      out_term_ovf_q <= out_term_ovf_d;
      out_count_q    <= out_count_d;
      out_valid_q    <= out_valid_d;
    end
  end
endmodule
